// File: rtl/xrv_imem_pkg.sv
// Shared types and constants for the instruction memory and its byte-serial program loader.
package xrv_imem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        COMMIT = 3'd2,
        FLUSH  = 3'd3,
        BOOT   = 3'd4
    } ld_state_t;

    // addi x0,x0,0: harmless filler for fetches beyond the array
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/xrv_imem_ram.sv
// Single-port-read / single-port-write synchronous RAM, read-first, no reset on contents.
module xrv_imem_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Both accesses share one edge, so a same-word read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/xrv_imem.sv
// Instruction memory with a one-cycle fetch port and a byte-serial loader that holds the core
// while a program image is written, then requests a restart at the image base address.
module xrv_imem
    import xrv_imem_pkg::*;
#(
    parameter int          DEPTH_WORDS   = 4096,
    parameter bit          HOLD_AT_RESET = 1'b1,
    parameter logic [31:0] NOP_WORD      = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    input  logic        ld_start,
    input  logic [31:0] ld_addr,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    input  logic        ld_done,
    output logic        cpu_hold,
    output logic        boot_req,
    output logic [31:0] boot_addr,
    output logic        err_oob
);

    localparam int AW = $clog2(DEPTH_WORDS);

    ld_state_t   state_reg, state_next;
    logic [AW-1:0] wptr_reg, wptr_next;
    logic [31:0] base_reg, base_next;
    logic [31:0] boot_addr_reg, boot_addr_next;
    logic [1:0]  bcnt_reg, bcnt_next;
    logic        pend_reg, pend_next;
    logic        last_reg, last_next;
    logic        cpu_hold_reg, cpu_hold_next;
    logic        err_oob_reg, err_oob_next;
    logic        rd_valid_reg, rd_oob_reg;

    logic        fetch_oob, start_oob, restart, byte_take, wbuf_clr, mem_we;
    logic [3:0]  lane_we;
    logic [31:0] wbuf, ram_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[1:0], ld_addr[1:0]};

    assign fetch_oob = |i_addr[31:AW+2];
    assign start_oob = |ld_addr[31:AW+2];
    assign restart   = ld_start && (state_reg inside {IDLE, LOAD, COMMIT});
    assign byte_take = (state_reg == LOAD) && ld_valid && !ld_start;
    assign wbuf_clr  = restart || (state_reg == COMMIT);

    // Word assembler: one byte lane per position, cleared to zero so a short tail is zero-padded.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            assign lane_we[gi] = byte_take && (bcnt_reg == 2'(gi));
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (wbuf_clr) begin
                    lane_reg <= '0;
                end else if (lane_we[gi]) begin
                    lane_reg <= ld_byte;
                end
            end
            assign wbuf[8*gi +: 8] = lane_reg;
        end
    endgenerate

    xrv_imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .rd_addr (i_addr[AW+1:2]),
        .rd_data (ram_q),
        .wr_en   (mem_we),
        .wr_addr (wptr_reg),
        .wr_data (wbuf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            wptr_reg      <= '0;
            base_reg      <= '0;
            boot_addr_reg <= '0;
            bcnt_reg      <= '0;
            pend_reg      <= 1'b0;
            last_reg      <= 1'b0;
            cpu_hold_reg  <= HOLD_AT_RESET;
            err_oob_reg   <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_oob_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wptr_reg      <= wptr_next;
            base_reg      <= base_next;
            boot_addr_reg <= boot_addr_next;
            bcnt_reg      <= bcnt_next;
            pend_reg      <= pend_next;
            last_reg      <= last_next;
            cpu_hold_reg  <= cpu_hold_next;
            err_oob_reg   <= err_oob_next;
            rd_valid_reg  <= 1'b1;
            rd_oob_reg    <= fetch_oob;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wptr_next      = wptr_reg;
        base_next      = base_reg;
        boot_addr_next = boot_addr_reg;
        bcnt_next      = bcnt_reg;
        pend_next      = pend_reg;
        last_next      = last_reg;
        cpu_hold_next  = cpu_hold_reg;
        err_oob_next   = err_oob_reg | fetch_oob;
        mem_we         = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            LOAD: begin
                if (byte_take) begin
                    bcnt_next = bcnt_reg + 2'd1;
                end
                // pend_reg carries an end-of-session request that arrived during COMMIT
                if (byte_take && (bcnt_reg == 2'd3)) begin
                    state_next = COMMIT;
                    last_next  = ld_done || pend_reg;
                end else if (ld_done || pend_reg) begin
                    state_next = (bcnt_next != 2'd0) ? COMMIT : FLUSH;
                    last_next  = (bcnt_next != 2'd0);
                end
                pend_next = 1'b0;
            end
            COMMIT: begin
                mem_we     = 1'b1;
                wptr_next  = wptr_reg + 1'b1;
                bcnt_next  = 2'd0;
                pend_next  = ld_done && !last_reg;
                last_next  = 1'b0;
                state_next = last_reg ? FLUSH : LOAD;
            end
            FLUSH: begin
                boot_addr_next = base_reg;
                cpu_hold_next  = 1'b0;
                state_next     = BOOT;
            end
            BOOT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new session overrides everything except a write already issued this cycle.
        if (restart) begin
            state_next    = LOAD;
            wptr_next     = ld_addr[AW+1:2];
            base_next     = word_align(ld_addr);
            bcnt_next     = 2'd0;
            pend_next     = 1'b0;
            last_next     = 1'b0;
            cpu_hold_next = 1'b1;
            if (start_oob) begin
                err_oob_next = 1'b1;
            end
        end
    end

    assign i_data    = !rd_valid_reg ? 32'h0 : (rd_oob_reg ? NOP_WORD : ram_q);
    assign ld_ready  = (state_reg == LOAD);
    assign boot_req  = (state_reg == BOOT);
    assign cpu_hold  = cpu_hold_reg;
    assign boot_addr = boot_addr_reg;
    assign err_oob   = err_oob_reg;

endmodule

// File: tb/tb_xrv_imem.sv
// Self-checking bench for xrv_imem: directed vectors, hand-written loader corner cases and
// randomized load sessions checked against a word-level memory image model.
module tb_xrv_imem;

    localparam int DEPTH = 128;
    localparam int AWT = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } fvec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        ld_start;
    logic [31:0] ld_addr;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_done;
    logic        cpu_hold;
    logic        boot_req;
    logic [31:0] boot_addr;
    logic        err_oob;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];

    xrv_imem #(
        .DEPTH_WORDS   (DEPTH),
        .HOLD_AT_RESET (1'b1),
        .NOP_WORD      (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .ld_start  (ld_start),
        .ld_addr   (ld_addr),
        .ld_valid  (ld_valid),
        .ld_byte   (ld_byte),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .cpu_hold  (cpu_hold),
        .boot_req  (boot_req),
        .boot_addr (boot_addr),
        .err_oob   (err_oob)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory image after a session: consecutive words from the base, little-endian, zero-padded tail.
    task automatic model_load(input logic [31:0] addr, input bq_t q);
        int w;
        int n;
        logic [31:0] word;
        w = int'(addr[AWT+1:2]);
        n = q.size();
        for (int k = 0; k < (n + 3) / 4; k++) begin
            word = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) word[8*j +: 8] = q[4*k+j];
            end
            model_mem[(w + k) % DEPTH]   = word;
            model_known[(w + k) % DEPTH] = 1'b1;
        end
    endtask

    task automatic fetch_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
        i_addr = addr;
        tick();
        check(name, i_data, exp);
        $display("fetch %-12s addr=0x%08h data=0x%08h", name, addr, i_data);
    endtask

    task automatic start_session(input logic [31:0] addr);
        ld_start = 1'b1;
        ld_addr  = addr;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) tick();
        t = 0;
        while (!ld_ready && t < 10) begin
            tick();
            t++;
        end
        check("ld_ready", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_byte  = b;
        tick();
        ld_valid = 1'b0;
    endtask

    // Entered just after the edge that sampled ld_done (that edge counts as cycle 1).
    task automatic wait_boot(input int exp_lat, input logic [31:0] exp_base, input string tag);
        int n;
        n = 1;
        while (!boot_req && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_boot_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_boot_addr"}, boot_addr, exp_base);
        tick();
        check({tag, "_boot_pulse"}, 32'(boot_req), 32'd0);
        check({tag, "_hold_rel"}, 32'(cpu_hold), 32'd0);
    endtask

    task automatic finish_session(input int exp_lat, input logic [31:0] base, input string tag);
        int t;
        t = 0;
        while (!ld_ready && t < 10) begin
            tick();
            t++;
        end
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        wait_boot(exp_lat, base, tag);
    endtask

    task automatic run_session(input logic [31:0] addr, input bq_t q, input int maxgap,
                               input string tag);
        int lat;
        start_session(addr);
        foreach (q[i]) send_byte(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        lat = ((q.size() % 4) != 0) ? 3 : 2;
        finish_session(lat, addr & 32'hFFFF_FFFC, tag);
        model_load(addr, q);
        $display("session %-8s addr=0x%08h bytes=%0d", tag, addr, q.size());
    endtask

    initial begin
        fvec_t vt [6];
        bq_t   q;
        bq_t   q2;
        logic [31:0] a;
        int    idx;
        int    n;
        int    seen;

        rst      = 1'b1;
        i_addr   = 32'h0;
        ld_start = 1'b0;
        ld_addr  = 32'h0;
        ld_valid = 1'b0;
        ld_byte  = 8'h0;
        ld_done  = 1'b0;

        // Reset state
        #12;
        check("rst_i_data", i_data, 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_boot_req", 32'(boot_req), 32'd0);
        check("rst_boot_addr", boot_addr, 32'h0);
        check("rst_err_oob", 32'(err_oob), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("hold_pre_load", 32'(cpu_hold), 32'd1);

        // Preload A,B,C then back-to-back fetches from a vector table
        q = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hC4, 8'hC3, 8'hC2, 8'hC1};
        run_session(32'h0, q, 0, "abc");
        vt[0] = '{32'h0, 32'hA1A2A3A4, "v_a"};
        vt[1] = '{32'h4, 32'hB1B2B3B4, "v_b"};
        vt[2] = '{32'h8, 32'hC1C2C3C4, "v_c"};
        vt[3] = '{32'h6, 32'hB1B2B3B4, "v_b_unalgn"};
        vt[4] = '{32'h3, 32'hA1A2A3A4, "v_a_unalgn"};
        vt[5] = '{32'hB, 32'hC1C2C3C4, "v_c_unalgn"};
        for (int i = 0; i < 6; i++) begin
            i_addr = vt[i].addr;
            tick();
            check(vt[i].name, i_data, vt[i].exp);
            $display("vector %-12s addr=0x%08h data=0x%08h", vt[i].name, vt[i].addr, i_data);
        end

        // Single aligned word at 0x100
        q = {8'h13, 8'h05, 8'h10, 8'h00};
        run_session(32'h100, q, 0, "w100");
        fetch_check(32'h100, 32'h00100513, "w100");

        // Six bytes: one full word and a zero-padded half word
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_session(32'h0, q, 0, "six");
        fetch_check(32'h0, 32'h44332211, "six_w0");
        fetch_check(32'h4, 32'h00006655, "six_w1");

        // ld_done arriving while the 4th byte is being committed
        start_session(32'h30);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        check("commit_ready", 32'(ld_ready), 32'd0);
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        wait_boot(3, 32'h30, "late_done");
        q = {8'h01, 8'h02, 8'h03, 8'h04};
        model_load(32'h30, q);
        fetch_check(32'h30, 32'h04030201, "late_done");

        // Same-word read during the commit write returns the old word
        q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_session(32'h14, q, 0, "w5_old");
        start_session(32'h14);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        i_addr = 32'h14;
        tick();
        check("rw_old", i_data, 32'hEFBEADDE);
        tick();
        check("rw_new", i_data, 32'h44332211);
        finish_session(2, 32'h14, "w5_new");
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        model_load(32'h14, q);

        // Restart mid-word: partial bytes and the same-cycle byte are discarded
        q = {8'h91, 8'h92, 8'h93, 8'h94};
        run_session(32'h40, q, 0, "w16");
        start_session(32'h40);
        send_byte(8'hE1, 0);
        send_byte(8'hE2, 0);
        ld_start = 1'b1;
        ld_addr  = 32'h20;
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        send_byte(8'h5A, 0);
        send_byte(8'h6B, 0);
        send_byte(8'h7C, 0);
        send_byte(8'h8D, 0);
        finish_session(2, 32'h20, "restart");
        q = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
        model_load(32'h20, q);
        fetch_check(32'h40, 32'h94939291, "rs_w16");
        fetch_check(32'h20, 32'h8D7C6B5A, "rs_w8");

        // Load starting at the last word wraps to word 0
        q = {8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};
        run_session(32'(DEPTH * 4 - 4), q, 0, "wrap");
        fetch_check(32'(DEPTH * 4 - 4), 32'hF3F2F1F0, "wrap_last");
        fetch_check(32'h0, 32'hF7F6F5F4, "wrap_w0");

        // Out-of-range fetch and load
        check("oob_clear", 32'(err_oob), 32'd0);
        fetch_check(32'(DEPTH * 4), NOP, "oob_fetch");
        check("oob_set", 32'(err_oob), 32'd1);
        fetch_check(32'h8, model_mem[2], "after_oob");
        check("oob_sticky", 32'(err_oob), 32'd1);
        q = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
        run_session(32'h1000_0012, q, 0, "oob_ld");
        fetch_check(32'h10, 32'hC3C2C1C0, "oob_ld_w4");

        // Randomized sessions against the image model
        for (int s = 0; s < 25; s++) begin
            a = 32'($urandom_range(0, DEPTH * 4 - 1));
            n = int'($urandom_range(0, 9));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            run_session(a, q, 2, "rand");
            for (int f = 0; f < 6; f++) begin
                idx = int'($urandom_range(0, DEPTH - 1));
                if (model_known[idx]) begin
                    fetch_check(32'(idx * 4) + 32'($urandom_range(0, 3)), model_mem[idx], "rand_fetch");
                end
            end
            fetch_check(32'(DEPTH * 4) + 32'($urandom_range(0, 4095)), NOP, "rand_oob");
        end

        // Reset in the middle of a session
        q = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        run_session(32'h80, q, 0, "pre_rst");
        start_session(32'h80);
        q2 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        foreach (q2[i]) send_byte(q2[i], 0);
        check("mid_load_ready", 32'(ld_ready), 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_ready", 32'(ld_ready), 32'd0);
        check("mrst_hold", 32'(cpu_hold), 32'd1);
        check("mrst_boot_req", 32'(boot_req), 32'd0);
        check("mrst_err_oob", 32'(err_oob), 32'd0);
        check("mrst_i_data", i_data, 32'h0);
        q2 = {8'h31, 8'h32, 8'h33, 8'h34};
        model_load(32'h80, q2);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (boot_req) seen++;
        end
        check("mrst_no_boot", 32'(seen), 32'd0);
        check("mrst_hold_kept", 32'(cpu_hold), 32'd1);
        fetch_check(32'h80, 32'h34333231, "mrst_w32");
        fetch_check(32'h84, 32'h28272625, "mrst_w33");
        fetch_check(32'h100, model_mem[64], "mrst_w64");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
